// File: rtl/fpu_pkg.sv
// Shared float-format definitions for the fpu and its consumers.
// Layout: sign[31], biased exponent[30:25] (bias 31), fraction[24:0] with hidden 1.
package fpu_pkg;
    localparam int EXP_W  = 6;
    localparam int MANT_W = 25;
    localparam int BIAS   = 31;
    localparam logic [EXP_W-1:0] EXP_MAX = 6'b111111;

    localparam int SIGN_BIT = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 25;
    localparam int FRAC_HI  = 24;
    localparam int FRAC_LO  = 0;

    typedef enum logic [1:0] {
        EXACT     = 2'd0,
        INEXACT   = 2'd1,
        OVERFLOW  = 2'd2,
        UNDERFLOW = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_SHIFT,
        S_FINISH
    } state_t;
endpackage

// File: rtl/fp_to_int_if.sv
// Request/result bundle between the fpu output stage and the float-to-int converter.
interface fp_to_int_if;
    logic        start;
    logic [31:0] fp_in;
    logic        busy;
    logic        done;
    logic [31:0] int_out;
    logic [3:0]  status_out;

    modport master (output start, fp_in, input busy, done, int_out, status_out);
    modport slave  (input start, fp_in, output busy, done, int_out, status_out);
endinterface

// File: rtl/fp_to_int_classify.sv
// Combinational decode of a float word: special-case result/status, or the
// shift count and direction that align the significand to an integer.
module fp_classify
    import fpu_pkg::*;
(
    input  logic [31:0] fp,
    output logic        special,
    output logic [31:0] spec_result,
    output status_t     spec_status,
    output logic [4:0]  shamt,
    output logic        shift_left
);
    localparam logic [EXP_W-1:0] E_BIAS = EXP_W'(BIAS);
    localparam logic [EXP_W-1:0] E_OVF  = EXP_MAX - 6'd1;            // E = 31
    localparam logic [EXP_W-1:0] E_UNIT = EXP_W'(BIAS + MANT_W);     // E = 25, no shift

    logic              s;
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] f;

    assign s = fp[SIGN_BIT];
    assign e = fp[EXP_HI:EXP_LO];
    assign f = fp[FRAC_HI:FRAC_LO];

    always_comb begin
        special     = 1'b1;
        spec_result = 32'd0;
        spec_status = EXACT;
        shamt       = 5'd0;
        shift_left  = 1'b0;
        if (e == '0 && f == '0) begin
            spec_status = EXACT;
        end else if (e == '0) begin
            spec_status = UNDERFLOW;
        end else if (e < E_BIAS) begin
            spec_status = INEXACT;
        end else if (e >= E_OVF) begin
            // -2^31 is the one representable value at E=31
            if (s && e == E_OVF && f == '0) begin
                spec_result = 32'h8000_0000;
                spec_status = EXACT;
            end else begin
                spec_result = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                spec_status = OVERFLOW;
            end
        end else begin
            special = 1'b0;
            if (e >= E_UNIT) begin
                shift_left = 1'b1;
                shamt      = 5'(e - E_UNIT);
            end else begin
                shamt      = 5'(E_UNIT - e);
            end
        end
    end
endmodule

// File: rtl/fp_to_int.sv
// Multicycle float-to-int32 converter, truncating toward zero, one shift bit per cycle.
module fp_to_int
    import fpu_pkg::*;
(
    input  logic         clock100KHz,
    input  logic         reset,
    fp_to_int_if.slave   bus
);
    state_t      state, state_nxt;
    logic [31:0] op_q;
    logic [31:0] acc;
    logic        sticky;
    logic [4:0]  cnt;
    logic        dir_left;
    logic        spec_q;
    logic [31:0] spec_res_q;
    status_t     spec_st_q;
    logic [31:0] int_q;
    status_t     stat_q;
    logic        done_q;

    logic        c_special;
    logic [31:0] c_result;
    status_t     c_status;
    logic [4:0]  c_shamt;
    logic        c_left;

    fp_classify u_classify (
        .fp          (op_q),
        .special     (c_special),
        .spec_result (c_result),
        .spec_status (c_status),
        .shamt       (c_shamt),
        .shift_left  (c_left)
    );

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_DECODE;
            S_DECODE: state_nxt = (c_special || c_shamt == 5'd0) ? S_FINISH : S_SHIFT;
            S_SHIFT:  if (cnt == 5'd1) state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            op_q       <= '0;
            acc        <= '0;
            sticky     <= 1'b0;
            cnt        <= '0;
            dir_left   <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            spec_st_q  <= EXACT;
            int_q      <= '0;
            stat_q     <= EXACT;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) op_q <= bus.fp_in;
                S_DECODE: begin
                    spec_q     <= c_special;
                    spec_res_q <= c_result;
                    spec_st_q  <= c_status;
                    acc        <= {6'b0, 1'b1, op_q[FRAC_HI:FRAC_LO]};
                    sticky     <= 1'b0;
                    cnt        <= c_shamt;
                    dir_left   <= c_left;
                end
                S_SHIFT: begin
                    cnt <= cnt - 5'd1;
                    if (dir_left) begin
                        acc <= acc << 1;
                    end else begin
                        acc    <= acc >> 1;
                        sticky <= sticky | acc[0];
                    end
                end
                S_FINISH: begin
                    done_q <= 1'b1;
                    if (spec_q) begin
                        int_q  <= spec_res_q;
                        stat_q <= spec_st_q;
                    end else begin
                        // magnitude is below 2^31 here, negation cannot wrap
                        int_q  <= op_q[SIGN_BIT] ? -acc : acc;
                        stat_q <= sticky ? INEXACT : EXACT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = done_q;
    assign bus.int_out    = int_q;
    assign bus.status_out = {2'b00, stat_q};
endmodule

// File: tb/tb_fp_to_int.sv
// Scoreboard bench for fp_to_int: a real-arithmetic reference model predicts each result.
module tb_fp_to_int;
    logic clock100KHz = 1'b0;
    logic reset = 1'b0;
    fp_to_int_if bus();

    fp_to_int dut (.clock100KHz(clock100KHz), .reset(reset), .bus(bus));

    always #5 clock100KHz = ~clock100KHz;

    typedef struct {
        logic [31:0] val;
        logic [3:0]  st;
        int          due;
        logic [31:0] op;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ndone = 0;

    always @(posedge clock100KHz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Value = (1 + f/2^25) * 2^(e-31), evaluated in real arithmetic.
    function automatic void model(input logic [31:0] x, output logic [31:0] r,
                                  output logic [3:0] st, output int lat);
        logic s;
        int   e, f, mag, ex;
        real  v, two31;
        s = x[31];
        e = int'(x[30:25]);
        f = int'(x[24:0]);
        two31 = 2147483648.0;
        lat = 2;
        r = 0;
        st = 0;
        if (e == 0) begin
            st = (f == 0) ? 4'd0 : 4'd3;
        end else begin
            ex = e - 31;
            v = (1.0 + real'(f) / 33554432.0) * (2.0 ** real'(ex));
            if (v >= two31) begin
                if (s && v == two31) begin
                    r = 32'h8000_0000; st = 4'd0;
                end else begin
                    r = s ? 32'h8000_0000 : 32'h7FFF_FFFF; st = 4'd2;
                end
            end else begin
                mag = $rtoi(v);
                r = s ? -mag : mag;
                st = (real'(mag) != v) ? 4'd1 : 4'd0;
                if (ex >= 0) lat = 2 + ((ex >= 25) ? ex - 25 : 25 - ex);
            end
        end
    endfunction

    always @(negedge clock100KHz) begin
        if (bus.done) begin
            exp_t ex;
            ndone++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%h required=no_done", bus.int_out);
            end else begin
                ex = sb.pop_front();
                check($sformatf("int_out[%h]", ex.op), bus.int_out, ex.val);
                check($sformatf("status[%h]", ex.op), {28'd0, bus.status_out}, {28'd0, ex.st});
                check($sformatf("latency[%h]", ex.op), cyc, ex.due);
            end
        end
    end

    task automatic push_exp(input logic [31:0] x);
        exp_t ex;
        int lat;
        model(x, ex.val, ex.st, lat);
        ex.due = cyc + lat;
        ex.op = x;
        sb.push_back(ex);
    endtask

    // Drive start in the current (negedge) cycle; the next posedge is the accept edge.
    task automatic issue_now(input logic [31:0] x);
        bus.start = 1'b1;
        bus.fp_in = x;
        @(posedge clock100KHz);
        #1;
        push_exp(x);
        bus.start = 1'b0;
    endtask

    task automatic issue(input logic [31:0] x);
        int n = 0;
        @(negedge clock100KHz);
        while (bus.busy && n < 100) begin
            @(negedge clock100KHz);
            n++;
        end
        if (bus.busy) begin
            checks++; errors++;
            $display("FAIL busy_timeout actual=busy required=idle");
        end
        issue_now(x);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clock100KHz);
        while (!bus.done && n < 100) begin
            @(negedge clock100KHz);
            n++;
        end
        if (!bus.done) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=no_done required=done");
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock100KHz);
            n++;
        end
        repeat (3) @(negedge clock100KHz);
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int d0;
        logic [31:0] x;
        logic [5:0]  e;
        logic [31:0] f;
        bus.start = 1'b0;
        bus.fp_in = '0;
        repeat (3) @(negedge clock100KHz);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_int", bus.int_out, 32'd0);
        check("reset_status", {28'd0, bus.status_out}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock100KHz);

        issue(32'h3E00_0000);
        drain();
        issue(32'hC080_0000);
        issue(32'h7A00_0000);
        issue(32'h7C00_0000);
        issue(32'hFC00_0000);
        issue(32'h0000_0000);
        issue(32'h0000_0001);
        issue(32'h3C00_0000);
        issue(32'h7BFF_FFFF);
        issue(32'hFE00_0000);
        drain();

        // start while busy is ignored, then restart in the done cycle
        issue(32'h3E00_0000);
        repeat (5) @(negedge clock100KHz);
        bus.start = 1'b1;
        bus.fp_in = 32'h7A00_0000;
        @(negedge clock100KHz);
        bus.start = 1'b0;
        wait_done();
        issue_now(32'h7A00_0000);
        drain();

        // reset abandons a conversion in flight
        issue(32'h3E00_0000);
        repeat (10) @(negedge clock100KHz);
        reset = 1'b0;
        #1;
        check("midreset_busy", {31'd0, bus.busy}, 32'd0);
        check("midreset_int", bus.int_out, 32'd0);
        check("midreset_status", {28'd0, bus.status_out}, 32'd0);
        sb.delete();
        d0 = ndone;
        repeat (3) @(negedge clock100KHz);
        reset = 1'b1;
        repeat (30) @(negedge clock100KHz);
        check("no_done_after_reset", ndone, d0);
        issue(32'h3E00_0000);
        drain();

        repeat (80) begin
            e = 6'($urandom_range(0, 63));
            f = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            x = {1'($urandom_range(0, 1)), e, f[24:0]};
            issue(x);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_to_int.md
Name: fp_to_int

Overview:
- Converts one value in the team's 32-bit float format to a signed 32-bit two's-complement integer.
- Float format: sign [31], exponent [30:25] with bias 31, fraction [24:0] with a hidden leading 1.
- Sits on the consumer side of the fpu: it takes the fpu's data_out word and hands integer results to the datapath.
- Multicycle; start/busy/done handshake; one shift bit per cycle.

Parameters:
- EXP_W, 6, exponent field width. Only the default is supported.
- MANT_W, 25, fraction field width. Only the default is supported.
- BIAS, 31, exponent bias.

Ports:
- clock100KHz  in  1  system clock. Only one clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- fp_in  in  32  float operand; captured on the accepted start edge.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when int_out and status_out are updated.
- int_out  out  32  signed integer result; held until the next done.
- status_out  out  4  status_t zero-extended: EXACT=0, INEXACT=1, OVERFLOW=2, UNDERFLOW=3.

Behaviour:
- Reset (async, reset=0): state=IDLE; busy=0, done=0, int_out=0, status_out=EXACT; internal registers cleared.
- Reset mid-operation: the conversion is abandoned and no done is produced.
- States: IDLE -> DECODE -> SHIFT (k cycles, k may be 0) -> FINISH -> IDLE.
- IDLE: on edge t0 with start=1, capture fp_in into op_q and go to DECODE. A start while busy is ignored and not queued.
- DECODE (edge t1): s=sign, e=exponent field, f=fraction, E=e-BIAS, sig={1,f} (26 bits). Classify in priority order:
  - e=0 and f=0: result 0, EXACT.
  - e=0 and f!=0: result 0, UNDERFLOW.
  - E<0: result 0, INEXACT.
  - E>=31, except s=1 with E=31 and f=0: saturate to 0x7FFFFFFF (s=0) or 0x80000000 (s=1), OVERFLOW.
  - s=1, E=31, f=0: result 0x80000000, EXACT.
  - Otherwise (0<=E<=30): load a 32-bit accumulator with sig, clear sticky.
    - If E>=25: k=E-25, direction left.
    - If E<25: k=25-E, direction right.
  - Special cases go straight to FINISH with k=0. Normal cases go to SHIFT, or to FINISH if k=0.
- SHIFT: one bit per cycle; down-counter k.
  - Right shifts OR the bit shifted out into sticky.
  - Leave SHIFT on the edge where the counter reaches 0.
- FINISH (edge t0+k+2):
  - int_out = s ? -acc : acc. Magnitude is at most 2^31-1 here, so negation never wraps.
  - status_out = sticky ? INEXACT : EXACT, or the special status set in DECODE.
  - done<=1 for exactly one cycle; state<=IDLE.
- Latency: done is visible k+2 edges after the start edge. Worst case k=25 (E=0) gives 27.
- Back-to-back: start may be reasserted in the cycle done is high; it is accepted because the state is already IDLE.
- The rounding mode is truncation toward zero.
- busy falls in the same cycle done rises.

Decomposition:
- fpu_pkg (shared with fpu):
  - status_t enum.
  - Constants EXP_W, MANT_W, BIAS, EXP_MAX=6'b111111.
  - Field-slice localparams for sign, exponent and fraction.
- One sub-module, fp_classify (combinational):
  - Inputs: fp word.
  - Outputs: special-case flag, special result, special status, shift count, shift direction.
  - fp_to_int keeps the FSM, shift accumulator, sticky logic and output registers.

Test Plan:
- Check after reset: fp_in=0x3E000000 (1.0), start -> done 27 edges after start; int_out=0x00000001, EXACT.
- fp_in=0xC0800000 (-2.5) -> int_out=0xFFFFFFFE, INEXACT, done at t0+26.
- fp_in=0x7A000000 (2^30) -> int_out=0x40000000, EXACT, done at t0+7. Then fp_in=0x7C000000 -> 0x7FFFFFFF, OVERFLOW, done at t0+2.
- Special cases, each with done at t0+2:
  - fp_in=0xFC000000 -> 0x80000000, EXACT.
  - 0x00000000 -> 0, EXACT.
  - 0x00000001 -> 0, UNDERFLOW.
  - 0x3C000000 (0.5) -> 0, INEXACT.
- Start 1.0 and pulse start again while busy -> exactly one done, int_out=1. Restart in the done cycle with 0x7A000000 -> second result correct.
- Assert reset=0 in the middle of the 1.0 conversion -> busy=0, int_out=0, status_out=0 immediately; no done. A new start then converts normally.
